clk_div_phase_prog: RTL and testbench

Programmable multi-channel clock divider with per-channel divide ratio, phase offset and enable, running off the single `clk_200K` source. Each channel produces a registered, glitch-free divided clock plus a one-cycle rising-edge tick. Out of reset it generates the fixed /2, /4 and /8 outputs (100K/50K/25K from 200K). Ratios and phases are reprogrammed at runtime through a valid/ready config port and applied only at period boundaries.

---
 rtl/clk_div_phase_prog_if.sv | 28 ++
 rtl/clk_div_phase_prog.sv | 188 ++++++++++++++++++
 tb/tb_clk_div_phase_prog.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_phase_prog_if.sv
// Configuration port of the programmable clock divider.
// A request carries the target channel, divide ratio, phase offset and enable.
// It transfers on a rising clock edge where cfg_valid && cfg_ready.
//   master : drives cfg_valid/cfg_ch/cfg_div/cfg_phase/cfg_en, samples cfg_ready
//   slave  : samples the request fields, drives cfg_ready
interface clk_div_phase_prog_if #(
  parameter int unsigned CH    = 3,
  parameter int unsigned CNT_W = 8
);
  localparam int unsigned CH_W = (CH > 1) ? $clog2(CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_phase;
  logic             cfg_en;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_phase, cfg_en,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_phase, cfg_en,
    output cfg_ready
  );
endinterface

// File: rtl/clk_div_phase_prog.sv
// Programmable multi-channel clock divider running off clk_200K.
// Each channel has its own divide ratio, phase offset and enable, and produces
// a registered divided clock (high while cnt < div/2) plus a one-cycle tick on
// every 0->1 transition of that clock. Out of reset channel i divides by
// 2^(i+1). New settings arrive through a single-entry pending register and are
// applied at the channel's period boundary (immediately if it is disabled).
// Ports:
//   clk_200K : source clock, all logic on its rising edge
//   rst      : asynchronous active-low reset
//   cfg      : configuration request port (valid/ready handshake)
//   sync     : realigns every enabled channel to its phase offset
//   clk_out  : divided clocks, one bit per channel
//   tick     : one-cycle pulse in the cycle clk_out[i] goes 0->1
// CNT_W must be at least 2 so the minimum ratio of 2 is representable.
module clk_div_phase_prog #(
  parameter int unsigned CH    = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk_200K,
  input  logic                 rst,
  clk_div_phase_prog_if.slave  cfg,
  input  logic                 sync,
  output logic [CH-1:0]        clk_out,
  output logic [CH-1:0]        tick
);

  localparam int unsigned CH_W = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  typedef enum logic {
    CFG_IDLE,
    CFG_PEND
  } cfg_state_t;

  // Default ratio 2^(idx+1), saturated to the largest representable value.
  function automatic logic [CNT_W-1:0] reset_div(input int unsigned idx);
    if (idx + 1 >= CNT_W) begin
      return '1;
    end
    return ONE << (idx + 1);
  endfunction

  cfg_state_t       state_q, state_d;
  logic [CH_W-1:0]  pend_ch_q, pend_ch_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic [CNT_W-1:0] pend_phase_q, pend_phase_d;
  logic             pend_en_q, pend_en_d;

  logic [CNT_W-1:0] div_q   [CH];
  logic [CNT_W-1:0] div_d   [CH];
  logic [CNT_W-1:0] phase_q [CH];
  logic [CNT_W-1:0] phase_d [CH];
  logic [CNT_W-1:0] cnt_q   [CH];
  logic [CNT_W-1:0] cnt_d   [CH];
  logic [CH-1:0]    en_q, en_d;
  logic [CH-1:0]    clk_q, clk_d;
  logic [CH-1:0]    tick_q, tick_d;

  logic [CH-1:0]    wrap;
  logic [CH-1:0]    hit;
  logic             apply_any;
  logic             ch_ok;
  logic [CNT_W-1:0] acc_div;
  logic [CNT_W-1:0] acc_phase;

  // Requests aimed past the last channel are swallowed without occupying
  // the pending register.
  assign ch_ok = (32'(cfg.cfg_ch) < CH);

  // Clamping is done once at acceptance so the pending register always
  // holds a legal ratio and a phase inside the period.
  always_comb begin
    acc_div   = (cfg.cfg_div < TWO) ? TWO : cfg.cfg_div;
    acc_phase = (cfg.cfg_phase >= acc_div) ? (acc_div - ONE) : cfg.cfg_phase;
  end

  // Per-channel next state. A pending apply outranks sync on the same
  // channel, which gives the same result as applying first and then syncing
  // with the freshly loaded phase.
  always_comb begin
    div_d     = div_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    en_d      = en_q;
    clk_d     = clk_q;
    tick_d    = '0;
    wrap      = '0;
    hit       = '0;
    apply_any = 1'b0;

    for (int unsigned i = 0; i < CH; i++) begin
      wrap[i] = (cnt_q[i] == div_q[i] - ONE);
      hit[i]  = (state_q == CFG_PEND) && (pend_ch_q == CH_W'(i)) &&
                (!en_q[i] || wrap[i]);

      if (hit[i]) begin
        apply_any  = 1'b1;
        div_d[i]   = pend_div_q;
        phase_d[i] = pend_phase_q;
        en_d[i]    = pend_en_q;
        if (pend_en_q) begin
          cnt_d[i] = pend_phase_q;
          clk_d[i] = (pend_phase_q < (pend_div_q >> 1));
        end else begin
          cnt_d[i] = pend_div_q - ONE;
          clk_d[i] = 1'b0;
        end
      end else if (en_q[i]) begin
        if (sync) begin
          cnt_d[i] = phase_q[i];
        end else if (wrap[i]) begin
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + ONE;
        end
        clk_d[i] = (cnt_d[i] < (div_q[i] >> 1));
      end else begin
        cnt_d[i] = div_q[i] - ONE;
        clk_d[i] = 1'b0;
      end

      tick_d[i] = clk_d[i] & ~clk_q[i];
    end
  end

  // Pending-request controller.
  always_comb begin
    state_d      = state_q;
    pend_ch_d    = pend_ch_q;
    pend_div_d   = pend_div_q;
    pend_phase_d = pend_phase_q;
    pend_en_d    = pend_en_q;

    unique case (state_q)
      CFG_IDLE: begin
        if (cfg.cfg_valid && ch_ok) begin
          state_d      = CFG_PEND;
          pend_ch_d    = cfg.cfg_ch;
          pend_div_d   = acc_div;
          pend_phase_d = acc_phase;
          pend_en_d    = cfg.cfg_en;
        end
      end
      CFG_PEND: begin
        if (apply_any) begin
          state_d = CFG_IDLE;
        end
      end
    endcase
  end

  assign cfg.cfg_ready = (state_q == CFG_IDLE);

  always_ff @(posedge clk_200K or negedge rst) begin
    if (!rst) begin
      state_q      <= CFG_IDLE;
      pend_ch_q    <= '0;
      pend_div_q   <= '0;
      pend_phase_q <= '0;
      pend_en_q    <= 1'b0;
      for (int unsigned i = 0; i < CH; i++) begin
        div_q[i]   <= reset_div(i);
        phase_q[i] <= '0;
        cnt_q[i]   <= reset_div(i) - ONE;
      end
      en_q   <= '1;
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      state_q      <= state_d;
      pend_ch_q    <= pend_ch_d;
      pend_div_q   <= pend_div_d;
      pend_phase_q <= pend_phase_d;
      pend_en_q    <= pend_en_d;
      div_q        <= div_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      en_q         <= en_d;
      clk_q        <= clk_d;
      tick_q       <= tick_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_clk_div_phase_prog.sv
// Self-checking bench for clk_div_phase_prog.
// The reference model describes each enabled channel by an anchor edge and
// the position it held there; the position at any later edge follows from
// modular arithmetic, and clk_out is (position < div/2). Directed scenarios
// pin the model with literal waveforms, then randomized traffic runs against it.
`timescale 1ns/1ps
module tb_clk_div_phase_prog;
  localparam int CH    = 3;
  localparam int CNT_W = 8;
  localparam int DMAX  = (2 ** CNT_W) - 1;

  logic          clk_200K = 1'b0;
  logic          rst;
  logic          sync;
  logic [CH-1:0] clk_out;
  logic [CH-1:0] tick;

  int checks = 0;
  int errors = 0;

  clk_div_phase_prog_if #(.CH(CH), .CNT_W(CNT_W)) cfg_if ();

  clk_div_phase_prog #(.CH(CH), .CNT_W(CNT_W)) dut (
    .clk_200K (clk_200K),
    .rst      (rst),
    .cfg      (cfg_if.slave),
    .sync     (sync),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  // 200 kHz source: 2.5 us half-period.
  always #2500 clk_200K = ~clk_200K;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int n = 0;
  int m_div    [CH];
  int m_phase  [CH];
  int m_anchor [CH];
  int m_apos   [CH];
  bit m_en     [CH];
  bit m_clk    [CH];
  bit m_tick   [CH];
  bit m_pend;
  int m_pch, m_pdiv, m_pphase;
  bit m_pen;

  function automatic int mpos_at(int i, int e);
    return (m_apos[i] + e - m_anchor[i]) % m_div[i];
  endfunction

  function automatic int mpos(int i);
    return mpos_at(i, n);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_div[i]    = ((2 ** (i + 1)) > DMAX) ? DMAX : (2 ** (i + 1));
      m_phase[i]  = 0;
      m_en[i]     = 1'b1;
      m_anchor[i] = n;
      m_apos[i]   = m_div[i] - 1;
      m_clk[i]    = 1'b0;
      m_tick[i]   = 1'b0;
    end
    m_pend = 1'b0;
  endtask

  task automatic model_edge();
    bit was_pend;
    bit applied;
    bit c;
    int d;
    int p;
    was_pend = m_pend;
    applied  = 1'b0;
    n++;
    for (int i = 0; i < CH; i++) begin
      if (was_pend && m_pch == i &&
          (!m_en[i] || mpos_at(i, n - 1) == m_div[i] - 1)) begin
        applied     = 1'b1;
        m_div[i]    = m_pdiv;
        m_phase[i]  = m_pphase;
        m_en[i]     = m_pen;
        m_anchor[i] = n;
        m_apos[i]   = m_pen ? m_pphase : m_pdiv - 1;
      end else if (m_en[i] && sync) begin
        m_anchor[i] = n;
        m_apos[i]   = m_phase[i];
      end
      c         = m_en[i] && (mpos(i) < m_div[i] / 2);
      m_tick[i] = c && !m_clk[i];
      m_clk[i]  = c;
    end
    if (applied) begin
      m_pend = 1'b0;
    end else if (!was_pend && cfg_if.cfg_valid && int'(cfg_if.cfg_ch) < CH) begin
      d        = (int'(cfg_if.cfg_div) < 2) ? 2 : int'(cfg_if.cfg_div);
      p        = (int'(cfg_if.cfg_phase) >= d) ? d - 1 : int'(cfg_if.cfg_phase);
      m_pend   = 1'b1;
      m_pch    = int'(cfg_if.cfg_ch);
      m_pdiv   = d;
      m_pphase = p;
      m_pen    = cfg_if.cfg_en;
    end
  endtask

  always @(posedge clk_200K or negedge rst) begin
    if (!rst) model_reset();
    else      model_edge();
  end

  // Every-cycle comparison against the model.
  always @(negedge clk_200K) begin
    for (int i = 0; i < CH; i++) begin
      chk($sformatf("model_clk_out[%0d]", i), int'(clk_out[i]), int'(m_clk[i]));
      chk($sformatf("model_tick[%0d]", i), int'(tick[i]), int'(m_tick[i]));
    end
    chk("model_cfg_ready", int'(cfg_if.cfg_ready), int'(!m_pend));
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int ch, input int dv, input int ph, input bit en);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 2'(ch);
    cfg_if.cfg_div   = 8'(dv);
    cfg_if.cfg_phase = 8'(ph);
    cfg_if.cfg_en    = en;
    @(negedge clk_200K);
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic wait_applied(input string tag);
    for (int k = 0; k < 600; k++) begin
      @(negedge clk_200K);
      if (!m_pend) return;
    end
    chk({tag, "_apply_timeout"}, 0, 1);
  endtask

  // Sixteen edges after reset release: /2, /4, /8 and a common first tick.
  task automatic check_release_pattern(input string tag);
    logic [15:0] s0, s1, s2, t2;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk_200K);
      s0[k] = clk_out[0];
      s1[k] = clk_out[1];
      s2[k] = clk_out[2];
      t2[k] = tick[2];
      if (k == 0) begin
        chk({tag, "_first_clk_out"}, int'(clk_out), 'h7);
        chk({tag, "_first_tick"}, int'(tick), 'h7);
      end
    end
    chk({tag, "_ch0_wave"}, int'(s0), 'h5555);
    chk({tag, "_ch1_wave"}, int'(s1), 'h3333);
    chk({tag, "_ch2_wave"}, int'(s2), 'h0F0F);
    chk({tag, "_ch2_ticks"}, int'(t2), 'h0101);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] w1, w2;
    logic [9:0]  w0, t0;
    logic [5:0]  w5;
    bit          found;

    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_div   = '0;
    cfg_if.cfg_phase = '0;
    cfg_if.cfg_en    = 1'b0;
    sync             = 1'b0;
    rst              = 1'b1;
    model_reset();
    #1 rst = 1'b0;
    #4;
    chk("reset_clk_out", int'(clk_out), 0);
    chk("reset_tick", int'(tick), 0);
    chk("reset_cfg_ready", int'(cfg_if.cfg_ready), 1);
    #5 rst = 1'b1;

    // Reset release: 100K / 50K / 25K.
    check_release_pattern("release");

    // Odd ratio on running ch0: applies at its wrap, 2 high / 3 low.
    send(0, 5, 0, 1'b1);
    chk("odd_ready_low_a", int'(cfg_if.cfg_ready), 0);
    @(negedge clk_200K);
    chk("odd_ready_low_b", int'(cfg_if.cfg_ready), 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_200K);
      w0[k] = clk_out[0];
      t0[k] = tick[0];
      if (k == 0) chk("odd_ready_back", int'(cfg_if.cfg_ready), 1);
    end
    chk("odd_ch0_wave", int'(w0), 'h063);
    chk("odd_ch0_ticks", int'(t0), 'h021);

    // Phase offset: ch1 phase 0, ch2 phase 2, realigned by sync.
    send(1, 8, 0, 1'b1);
    wait_applied("phase_ch1");
    send(2, 8, 2, 1'b1);
    wait_applied("phase_ch2");
    sync = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk_200K);
      if (k == 0) sync = 1'b0;
      w1[k] = clk_out[1];
      w2[k] = clk_out[2];
    end
    chk("phase_ch1_wave", int'(w1), 'h0F0F);
    chk("phase_ch2_wave", int'(w2), 'hC3C3);

    // Disable ch1, confirm sync has no effect, then re-enable at phase 3.
    send(1, 4, 0, 1'b0);
    wait_applied("disable");
    chk("disabled_clk_out", int'(clk_out[1]), 0);
    sync = 1'b1;
    @(negedge clk_200K);
    sync = 1'b0;
    chk("disabled_sync_clk", int'(clk_out[1]), 0);
    chk("disabled_sync_tick", int'(tick[1]), 0);
    send(1, 4, 3, 1'b1);
    chk("reenable_ready_low", int'(cfg_if.cfg_ready), 0);
    @(negedge clk_200K);
    chk("reenable_applied_clk", int'(clk_out[1]), 0);
    chk("reenable_ready_back", int'(cfg_if.cfg_ready), 1);
    @(negedge clk_200K);
    chk("reenable_first_clk", int'(clk_out[1]), 1);
    chk("reenable_first_tick", int'(tick[1]), 1);

    // Clamping: div 1 -> 2, phase 9 -> 1.
    send(0, 1, 9, 1'b1);
    wait_applied("clamp");
    chk("clamp_apply_clk", int'(clk_out[0]), 0);
    @(negedge clk_200K);
    chk("clamp_next_clk", int'(clk_out[0]), 1);
    chk("clamp_next_tick", int'(tick[0]), 1);
    @(negedge clk_200K);
    chk("clamp_third_clk", int'(clk_out[0]), 0);

    // Out-of-range channel: swallowed, ready never drops.
    send(3, 7, 0, 1'b1);
    chk("badch_ready", int'(cfg_if.cfg_ready), 1);

    // Apply and sync on the same edge: the new phase wins.
    send(2, 6, 4, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 16 && !found; k++) begin
      if (mpos(2) == m_div[2] - 1) found = 1'b1;
      else @(negedge clk_200K);
    end
    chk("apply_sync_wrap_found", int'(found), 1);
    sync = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_200K);
      if (k == 0) begin
        sync = 1'b0;
        chk("apply_sync_ready", int'(cfg_if.cfg_ready), 1);
      end
      w5[k] = clk_out[2];
    end
    chk("apply_sync_ch2_wave", int'(w5), 'h1C);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      cfg_if.cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_if.cfg_ch    = 2'($urandom_range(0, 3));
      cfg_if.cfg_div   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                     : 8'($urandom_range(0, 12));
      cfg_if.cfg_phase = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                     : 8'($urandom_range(0, 12));
      cfg_if.cfg_en    = ($urandom_range(0, 3) != 0);
      sync             = ($urandom_range(0, 24) == 0);
      @(negedge clk_200K);
    end
    cfg_if.cfg_valid = 1'b0;
    sync             = 1'b0;
    if (m_pend) wait_applied("random_drain");

    // Reset with a request pending.
    send(2, 50, 0, 1'b1);
    #100 rst = 1'b0;
    #1;
    chk("midreset_clk_out", int'(clk_out), 0);
    chk("midreset_tick", int'(tick), 0);
    chk("midreset_cfg_ready", int'(cfg_if.cfg_ready), 1);
    @(negedge clk_200K);
    @(negedge clk_200K);
    #100 rst = 1'b1;
    check_release_pattern("rerelease");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
